kamus_decode_stage: RTL

Registered, flow-controlled decode stage for the kamus core. It buffers fetched instructions in a DEPTH-entry queue and extracts register addresses and the sign-extended immediate. It flags illegal encodings and detects load-use hazards against the EX stage. Decoded results are presented through a valid/ready output register to EX, with flush support for branch redirects.

---
 rtl/kamus_decode_stage_if.sv | 44 ++++
 rtl/kamus_decode_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/kamus_decode_stage_if.sv
// Handshake and decoded-result bundle between IF, the decode stage and EX.
// The stage itself connects through the slave modport; the producer/consumer side uses master.
interface kamus_decode_stage_if #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                flush_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [31:0]         in_instr_i;
  logic [PC_WIDTH-1:0] in_pc_i;
  logic                ex_load_valid_i;
  logic [4:0]          ex_load_rd_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [6:0]          out_opcode_o;
  logic [2:0]          out_funct3_o;
  logic [6:0]          out_funct7_o;
  logic [4:0]          out_rd_o;
  logic [4:0]          out_rs1_o;
  logic [4:0]          out_rs2_o;
  logic [31:0]         out_imm_o;
  logic                out_imm_used_o;
  logic                out_illegal_o;
  logic [PC_WIDTH-1:0] out_pc_o;
  logic [CNT_W-1:0]    count_o;
  logic                hazard_o;

  modport master (
    output flush_i, in_valid_i, in_instr_i, in_pc_i, ex_load_valid_i, ex_load_rd_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_opcode_o, out_funct3_o, out_funct7_o, out_rd_o,
           out_rs1_o, out_rs2_o, out_imm_o, out_imm_used_o, out_illegal_o, out_pc_o,
           count_o, hazard_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_instr_i, in_pc_i, ex_load_valid_i, ex_load_rd_i, out_ready_i,
    output in_ready_o, out_valid_o, out_opcode_o, out_funct3_o, out_funct7_o, out_rd_o,
           out_rs1_o, out_rs2_o, out_imm_o, out_imm_used_o, out_illegal_o, out_pc_o,
           count_o, hazard_o
  );
endinterface

// File: rtl/kamus_decode_stage.sv
// Decode stage: instruction queue, combinational decode of the queue head,
// load-use hazard detection and a valid/ready output register towards EX.
module kamus_decode_stage #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  kamus_decode_stage_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  logic [31:0]         instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]    wptr, rptr;
  logic [CNT_W-1:0]    count;

  logic [31:0]         head;
  logic [31:0]         imm;
  logic                imm_used, illegal, uses_rs1, uses_rs2;
  logic                in_ready, non_empty, hazard, enq, load_en;

  logic                out_valid, out_imm_used, out_illegal;
  logic [6:0]          out_opcode, out_funct7;
  logic [2:0]          out_funct3;
  logic [4:0]          out_rd, out_rs1, out_rs2;
  logic [31:0]         out_imm;
  logic [PC_WIDTH-1:0] out_pc;

  assign head      = instr_mem[rptr];
  assign non_empty = (count != '0);
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign enq       = bus.in_valid_i && in_ready && !bus.flush_i;
  assign load_en   = non_empty && !hazard && (!out_valid || bus.out_ready_i);

  always_comb begin
    imm      = '0;
    imm_used = 1'b0;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (head[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm      = {head[31:12], 12'b0};
        imm_used = 1'b1;
      end
      OPC_JAL: begin
        imm      = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
        imm_used = 1'b1;
      end
      OPC_JALR: begin
        imm      = {{20{head[31]}}, head[31:20]};
        imm_used = 1'b1;
        uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        imm      = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
        imm_used = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        illegal  = (head[14:12] == 3'b010) || (head[14:12] == 3'b011);
      end
      OPC_LOAD: begin
        imm      = {{20{head[31]}}, head[31:20]};
        imm_used = 1'b1;
        uses_rs1 = 1'b1;
        illegal  = (head[14:12] == 3'b011) || (head[14:12] == 3'b110) || (head[14:12] == 3'b111);
      end
      OPC_STORE: begin
        imm      = {{20{head[31]}}, head[31:25], head[11:7]};
        imm_used = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        illegal  = (head[14:12] > 3'b010);
      end
      OPC_OP_IMM: begin
        imm      = {{20{head[31]}}, head[31:20]};
        imm_used = 1'b1;
        uses_rs1 = 1'b1;
        // RV32 shift amounts are 5 bits; bit 25 set would be a 64-bit shamt
        illegal  = ((head[14:12] == 3'b001) || (head[14:12] == 3'b101)) && head[25];
      end
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_MISC_MEM: ;
      OPC_SYSTEM: begin
        imm      = {27'b0, head[19:15]};
        imm_used = head[14];
      end
      default: illegal = 1'b1;
    endcase
    if (head[1:0] != 2'b11) illegal = 1'b1;
  end

  assign hazard = non_empty && bus.ex_load_valid_i && (bus.ex_load_rd_i != 5'd0) &&
                  ((uses_rs1 && head[19:15] == bus.ex_load_rd_i) ||
                   (uses_rs2 && head[24:20] == bus.ex_load_rd_i));

  always_ff @(posedge clk_i) begin
    if (enq && rst_ni) begin
      instr_mem[wptr] <= bus.in_instr_i;
      pc_mem[wptr]    <= bus.in_pc_i;
    end
  end

  // Flush drops queue contents and the output valid but keeps stale data fields
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7   <= '0;
      out_rd       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_imm      <= '0;
      out_imm_used <= 1'b0;
      out_illegal  <= 1'b0;
      out_pc       <= '0;
    end else if (bus.flush_i) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (enq) wptr <= wptr + PTR_W'(1);
      if (load_en) begin
        rptr         <= rptr + PTR_W'(1);
        out_valid    <= 1'b1;
        out_opcode   <= head[6:0];
        out_funct3   <= head[14:12];
        out_funct7   <= head[31:25];
        out_rd       <= head[11:7];
        out_rs1      <= head[19:15];
        out_rs2      <= head[24:20];
        out_imm      <= imm;
        out_imm_used <= imm_used;
        out_illegal  <= illegal;
        out_pc       <= pc_mem[rptr];
      end else if (bus.out_ready_i) begin
        out_valid <= 1'b0;
      end
      count <= count + CNT_W'(enq) - CNT_W'(load_en);
    end
  end

  assign bus.in_ready_o     = in_ready;
  assign bus.out_valid_o    = out_valid;
  assign bus.out_opcode_o   = out_opcode;
  assign bus.out_funct3_o   = out_funct3;
  assign bus.out_funct7_o   = out_funct7;
  assign bus.out_rd_o       = out_rd;
  assign bus.out_rs1_o      = out_rs1;
  assign bus.out_rs2_o      = out_rs2;
  assign bus.out_imm_o      = out_imm;
  assign bus.out_imm_used_o = out_imm_used;
  assign bus.out_illegal_o  = out_illegal;
  assign bus.out_pc_o       = out_pc;
  assign bus.count_o        = count;
  assign bus.hazard_o       = hazard;
endmodule
